qwi_reg_arb: RTL and testbench
==============================

QWI_REG_ARB -- requirements
Module: qwi_reg_arb

Interface
REQ-001 SHALL have parameter AWID, default 12, register address width.
REQ-002 SHALL have parameter DWID, default 32, register data width (multiple of 8).
REQ-003 SHALL have port reg_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reg_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports m0_req and m1_req, input, 1 each, level request from requester 0/1.
REQ-006 SHALL have ports m0_wr and m1_wr, input, 1 each; 1 = full-word write, 0 = read.
REQ-007 SHALL have ports m0_addr and m1_addr, input, AWID each, register index.
REQ-008 SHALL have ports m0_wrd and m1_wrd, input, DWID each, write data.
REQ-009 SHALL have ports m0_ack and m1_ack, output, 1 each, one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdd and m1_rdd, output, DWID each, read data, valid with ack.
REQ-011 SHALL have ports reg_ce (1), reg_we (DWID/8), reg_addr (AWID) and reg_wrd (DWID), all outputs, driving the shared register bank.
REQ-012 SHALL have port reg_rdd, input, DWID, combinational read data from the register bank.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with three states: IDLE, GRANT and ACK.
REQ-015 IDLE: with no request pending, SHALL stay in IDLE; with any request pending, SHALL latch the winner's wr/addr/wrd and port id, then go to GRANT.
REQ-016 Arbitration SHALL be round-robin; last_gnt SHALL reset to 1, so port 0 wins the first tie.
REQ-017 A tie SHALL go to the port not equal to last_gnt; a single request always wins.
REQ-018 last_gnt SHALL update only on the IDLE->GRANT transition.
REQ-019 GRANT: SHALL drive reg_ce=1 and reg_addr/reg_wrd from the latched values.
REQ-020 GRANT: reg_we SHALL be all ones for a write and all zeros for a read.
REQ-021 GRANT: SHALL capture reg_rdd into the winner's rdd register, then go to ACK unconditionally.
REQ-022 ACK: SHALL pulse the winner's ack for exactly one cycle, then return to IDLE.
REQ-023 Outside GRANT, reg_ce SHALL be 0 and reg_we all zeros.
REQ-024 Outside GRANT, reg_addr/reg_wrd SHALL hold their last latched values.
REQ-025 Latency from req first sampled in IDLE to ack SHALL be 3 cycles (IDLE, GRANT, ACK), with ack in the 3rd cycle.
REQ-026 Throughput SHALL be one access per 3 cycles maximum.
REQ-027 A requester SHALL hold req, wr, addr and wrd until its ack.
REQ-028 Inputs SHALL be sampled only in IDLE; later changes SHALL not affect an access in flight.
REQ-029 A req dropped after grant SHALL NOT abort the access; the bus cycle and ack SHALL still occur.
REQ-030 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-031 mN_rdd SHALL hold its value until that port's next granted access; for writes it SHALL take the reg_rdd value sampled in GRANT (pre-write contents).
REQ-032 At most one of m0_ack/m1_ack SHALL be high in any cycle, and never two acks on one port without an intervening grant.

Reset
REQ-033 reg_rst sampled high SHALL force state IDLE, last_gnt=1, reg_ce=0, reg_we=0, reg_addr=0, reg_wrd=0, m0_ack=m1_ack=0, m0_rdd=m1_rdd=0 and busy=0 on the following edge.
REQ-034 Reset during GRANT or ACK SHALL abort the access with no ack; the aborted requester SHALL re-request.
REQ-035 Requests sampled while reg_rst is high SHALL be ignored.

Verification
REQ-036 Read, single port: m0_req=1, m0_wr=0, m0_addr=5, reg_rdd=0x1234_5678 during GRANT -> reg_ce=1, reg_we=0x0, reg_addr=5 for one cycle; m0_ack high in the 3rd cycle with m0_rdd=0x1234_5678.
REQ-037 Write, single port: m1_req=1, m1_wr=1, m1_addr=3, m1_wrd=0xDEAD_BEEF -> reg_we=0xF, reg_addr=3, reg_wrd=0xDEAD_BEEF for exactly one cycle; m1_ack one pulse; m0_ack stays 0.
REQ-038 Contention after reset: both reqs held high for 12 cycles -> grants alternate 0,1,0,1 (4 accesses, acks in cycles 3,6,9,12); no ack overlap.
REQ-039 Req drop: m0_req=1 for one cycle only -> access still completes; exactly one m0_ack; busy returns to 0.
REQ-040 Reset in GRANT: assert reg_rst in the GRANT cycle -> no ack; next cycle all outputs at reset values; a subsequent tie is granted to port 0.

Source files
------------

// File: rtl/qwi_reg_arb.sv
// Two-requester round-robin arbiter in front of a shared single-port register bank.
// Each access takes IDLE -> GRANT (one bus cycle) -> ACK (one-cycle completion pulse).
module qwi_reg_arb #(
   parameter int AWID = 12,
   parameter int DWID = 32
) (
   input  logic              reg_clk,
   input  logic              reg_rst,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_wr,
   input  logic              m1_wr,
   input  logic [AWID-1:0]   m0_addr,
   input  logic [AWID-1:0]   m1_addr,
   input  logic [DWID-1:0]   m0_wrd,
   input  logic [DWID-1:0]   m1_wrd,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic [DWID-1:0]   m0_rdd,
   output logic [DWID-1:0]   m1_rdd,
   output logic              reg_ce,
   output logic [DWID/8-1:0] reg_we,
   output logic [AWID-1:0]   reg_addr,
   output logic [DWID-1:0]   reg_wrd,
   input  logic [DWID-1:0]   reg_rdd,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_gnt;
   logic              gnt_id;
   logic              win_id;
   logic              any_req;
   logic              lat_wr;
   logic [AWID-1:0]   lat_addr;
   logic [DWID-1:0]   lat_wrd;

   // On a tie the port that did not win last time goes first; a lone request always wins.
   assign any_req = m0_req | m1_req;
   assign win_id  = (m0_req && m1_req) ? ~last_gnt : ~m0_req;

   always_ff @(posedge reg_clk) begin
      if (reg_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      reg_ce    = 1'b0;
      reg_we    = '0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) begin
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            reg_ce    = 1'b1;
            reg_we    = lat_wr ? '1 : '0;
            state_nxt = ACK;
         end
         ACK: begin
            m0_ack    = ~gnt_id;
            m1_ack    = gnt_id;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request fields are captured only when leaving IDLE, so requesters may change
   // or drop their inputs mid-access without disturbing it.
   always_ff @(posedge reg_clk) begin
      if (reg_rst) begin
         last_gnt <= 1'b1;
         gnt_id   <= 1'b0;
         lat_wr   <= 1'b0;
         lat_addr <= '0;
         lat_wrd  <= '0;
         m0_rdd   <= '0;
         m1_rdd   <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            last_gnt <= win_id;
            gnt_id   <= win_id;
            lat_wr   <= win_id ? m1_wr   : m0_wr;
            lat_addr <= win_id ? m1_addr : m0_addr;
            lat_wrd  <= win_id ? m1_wrd  : m0_wrd;
         end
         // Read data is taken in the bus cycle, so a write returns the pre-write contents.
         if (state == GRANT) begin
            if (gnt_id) begin
               m1_rdd <= reg_rdd;
            end else begin
               m0_rdd <= reg_rdd;
            end
         end
      end
   end

   assign reg_addr = lat_addr;
   assign reg_wrd  = lat_wrd;

endmodule

// File: tb/tb_qwi_reg_arb.sv
// Scoreboard bench for qwi_reg_arb: transaction-level reference model feeds an expected
// queue, a negedge monitor pops it on every ack and checks the bus cycle and read data.
module tb_qwi_reg_arb;
   localparam int AWID  = 12;
   localparam int DWID  = 32;
   localparam int BW    = DWID / 8;
   localparam int DEPTH = 1 << AWID;

   logic            clk = 1'b0;
   logic            reg_rst;
   logic            m0_req, m1_req, m0_wr, m1_wr;
   logic [AWID-1:0] m0_addr, m1_addr;
   logic [DWID-1:0] m0_wrd, m1_wrd;
   logic            m0_ack, m1_ack;
   logic [DWID-1:0] m0_rdd, m1_rdd;
   logic            reg_ce;
   logic [BW-1:0]   reg_we;
   logic [AWID-1:0] reg_addr;
   logic [DWID-1:0] reg_wrd;
   logic [DWID-1:0] reg_rdd;
   logic            busy;

   always #5 clk = ~clk;

   qwi_reg_arb #(.AWID(AWID), .DWID(DWID)) dut (
      .reg_clk(clk), .reg_rst(reg_rst),
      .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wrd(m0_wrd), .m1_wrd(m1_wrd),
      .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdd(m0_rdd), .m1_rdd(m1_rdd),
      .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wrd(reg_wrd),
      .reg_rdd(reg_rdd), .busy(busy)
   );

   typedef struct {
      logic            id;
      logic            wr;
      logic [AWID-1:0] addr;
      logic [DWID-1:0] wrd;
      logic [DWID-1:0] rdata;
      int              ack_cyc;
   } item_t;

   item_t           q[$];
   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              left = 0;
   logic            last = 1'b1;
   logic            rst_seen = 1'b0;
   logic [AWID-1:0] exp_addr = '0;
   logic [DWID-1:0] exp_wrd = '0;
   logic [DWID-1:0] bank [0:DEPTH-1];
   logic [DWID-1:0] ref_mem [0:DEPTH-1];
   logic [DWID-1:0] mon_rdd [0:1];
   int              ce_cnt = 0;

   function automatic logic [DWID-1:0] init_val(input int i);
      if (i == 5) return 32'h1234_5678;
      return (DWID'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Register bank: combinational read, full-word write at the end of the bus cycle.
   assign reg_rdd = bank[reg_addr];
   initial begin
      for (int i = 0; i < DEPTH; i++) bank[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (reg_ce && (&reg_we)) bank[reg_addr] <= reg_wrd;
      end
   end

   // Reference model: one access per three cycles, round-robin on ties, memory updated per transaction.
   initial begin
      item_t it;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         cyc++;
         if (reg_rst) begin
            q.delete();
            left     = 0;
            last     = 1'b1;
            exp_addr = '0;
            exp_wrd  = '0;
            rst_seen = 1'b1;
         end else begin
            rst_seen = 1'b0;
            if (left > 0) begin
               left--;
            end else if (m0_req || m1_req) begin
               it.id      = (m0_req && m1_req) ? !last : m1_req;
               last       = it.id;
               it.wr      = it.id ? m1_wr : m0_wr;
               it.addr    = it.id ? m1_addr : m0_addr;
               it.wrd     = it.id ? m1_wrd : m0_wrd;
               it.rdata   = ref_mem[it.addr];
               if (it.wr) ref_mem[it.addr] = it.wrd;
               it.ack_cyc = cyc + 1;
               q.push_back(it);
               left       = 2;
               exp_addr   = it.addr;
               exp_wrd    = it.wrd;
            end
         end
      end
   end

   // Monitor
   initial begin
      item_t         it;
      logic          a0, a1;
      logic [BW-1:0] we_exp;
      mon_rdd[0] = '0;
      mon_rdd[1] = '0;
      forever begin
         @(negedge clk);
         if (rst_seen) begin
            check("rst_ce", reg_ce, 0);
            check("rst_we", reg_we, 0);
            check("rst_addr", reg_addr, 0);
            check("rst_wrd", reg_wrd, 0);
            check("rst_ack0", m0_ack, 0);
            check("rst_ack1", m1_ack, 0);
            check("rst_rdd0", m0_rdd, 0);
            check("rst_rdd1", m1_rdd, 0);
            check("rst_busy", busy, 0);
            mon_rdd[0] = '0;
            mon_rdd[1] = '0;
            ce_cnt = 0;
         end
         check("busy", busy, left != 0);
         check("addr_hold", reg_addr, exp_addr);
         check("wrd_hold", reg_wrd, exp_wrd);
         if (reg_ce) begin
            ce_cnt++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bus_unexpected: reg_ce=1 with no access expected (cycle %0d)", cyc);
            end else begin
               we_exp = q[0].wr ? '1 : '0;
               check("bus_we", reg_we, we_exp);
               check("bus_cycle", cyc, q[0].ack_cyc - 1);
            end
         end else begin
            check("we_idle", reg_we, 0);
         end
         check("ack_overlap", m0_ack && m1_ack, 0);
         a0 = m0_ack;
         a1 = m1_ack;
         if (a0 || a1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_unexpected: ack0=%0b ack1=%0b with no access expected (cycle %0d)", a0, a1, cyc);
            end else begin
               it = q.pop_front();
               check("ack_port", a1, it.id);
               check("ack_rdd", it.id ? m1_rdd : m0_rdd, it.rdata);
               check("ack_cycle", cyc, it.ack_cyc);
               check("bus_count", ce_cnt, 1);
               mon_rdd[it.id] = it.rdata;
               ce_cnt = 0;
            end
         end
         if (!a0) check("rdd0_hold", m0_rdd, mon_rdd[0]);
         if (!a1) check("rdd1_hold", m1_rdd, mon_rdd[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input int p, input int lim, input string name);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         if (p == 0 ? m0_ack : m1_ack) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no ack within %0d cycles", name, lim);
      end
   endtask

   task automatic agent(input logic ack, inout bit pend, inout logic req, inout logic wr,
                        inout logic [AWID-1:0] addr, inout logic [DWID-1:0] wrd);
      if (pend && ack) begin
         if ($urandom % 8 != 0) begin
            req  = 1'b0;
            pend = 0;
         end
      end else if (pend && $urandom % 20 == 0) begin
         req  = 1'b0;
         pend = 0;
      end
      if (!pend && !req && $urandom % 3 == 0) begin
         req  = 1'b1;
         wr   = 1'($urandom % 2);
         addr = AWID'($urandom % 16);
         wrd  = $urandom;
         pend = 1;
      end
   endtask

   initial begin
      bit   pend0 = 0, pend1 = 0;
      logic s0, s1;
      bit   got;
      reg_rst = 1'b1;
      m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
      m0_addr = '0; m1_addr = '0; m0_wrd = '0; m1_wrd = '0;
      repeat (3) @(posedge clk);
      #2 reg_rst = 1'b0;

      // Single-port read of a preloaded register
      m0_req = 1; m0_wr = 0; m0_addr = 5; m0_wrd = $urandom;
      wait_ack(0, 10, "rd5_ack");
      check("rd5_data", m0_rdd, 32'h1234_5678);
      step(); m0_req = 0;
      repeat (2) step();

      // Single-port write from port 1, then read it back through port 0
      m1_req = 1; m1_wr = 1; m1_addr = 3; m1_wrd = 32'hDEAD_BEEF;
      wait_ack(1, 10, "wr3_ack");
      check("wr3_m0_ack", m0_ack, 0);
      step(); m1_req = 0;
      repeat (2) step();
      m0_req = 1; m0_wr = 0; m0_addr = 3;
      wait_ack(0, 10, "rb3_ack");
      check("rb3_data", m0_rdd, 32'hDEAD_BEEF);
      step(); m0_req = 0;

      // Contention straight after reset: acks alternate 0,1,0,1 every third cycle
      reg_rst = 1; step(); reg_rst = 0;
      m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0; m0_addr = 7; m1_addr = 9;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("cont_ack0", m0_ack, (k % 3 == 0) && ((k / 3) % 2 == 1));
         check("cont_ack1", m1_ack, (k % 3 == 0) && ((k / 3) % 2 == 0));
      end
      step(); m0_req = 0; m1_req = 0;
      repeat (2) step();

      // Request dropped after one cycle still completes exactly once
      m0_req = 1; m0_wr = 1; m0_addr = 11; m0_wrd = 32'h0BAD_F00D;
      step(); m0_req = 0;
      wait_ack(0, 5, "drop_ack");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("drop_no_second_ack", m0_ack, 0);
      end
      check("drop_busy", busy, 0);
      step();

      // Reset during the bus cycle aborts; the retried tie goes to port 0
      m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 1; m0_addr = 2; m1_addr = 4; m1_wrd = 32'hCAFE_0001;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (reg_ce) got = 1;
      end
      check("rstg_reached_grant", got, 1);
      #2 reg_rst = 1;
      step(); reg_rst = 0;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            got = 1;
            check("rstg_tie_port0", m0_ack, 1);
            check("rstg_tie_not1", m1_ack, 0);
         end
      end
      check("rstg_ack_seen", got, 1);
      step(); m0_req = 0; m1_req = 0;
      repeat (2) step();

      // Randomized traffic with occasional early drops, held requests and resets
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         s0 = m0_ack;
         s1 = m1_ack;
         step();
         reg_rst = ($urandom % 250 == 0);
         agent(s0, pend0, m0_req, m0_wr, m0_addr, m0_wrd);
         agent(s1, pend1, m1_req, m1_wr, m1_addr, m1_wrd);
      end

      // Drain
      step();
      reg_rst = 0; m0_req = 0; m1_req = 0;
      repeat (6) step();
      check("drain_queue", q.size(), 0);
      check("drain_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
